alu_packet_deser: RTL and testbench
===================================

ALU_PACKET_DESER -- requirements
Module: alu_packet_deser

Interface
- REQ-001 Parameter NDATA, default 8, number of data packets per frame (NDATA/2 bytes for A, then NDATA/2 bytes for B).
- REQ-002 clk  input  1  single system clock, all state updates on rising edge.
- REQ-003 rst  input  1  reset, synchronous, active-high.
- REQ-004 i_sin  input  1  serial line, idle high.
- REQ-005 o_a  output  32  operand A of last accepted frame.
- REQ-006 o_b  output  32  operand B of last accepted frame.
- REQ-007 o_op  output  3  opcode of last accepted frame.
- REQ-008 o_valid  output  1  one-cycle pulse: frame result (good or error) available.
- REQ-009 o_err  output  3  {err_frame, err_crc, err_data}, qualified by o_valid.

Function
- REQ-010 Packet SHALL be 11 bits, one per clk: start(0), type (0=data, 1=control), 8 payload bits MSB first, stop(1).
- REQ-011 Idle: start SHALL be detected on first sampled i_sin=0 while in IDLE.
- REQ-012 FSM states SHALL be IDLE, TYPE, PAYLOAD, STOP, WAIT_IDLE; IDLE->TYPE on start, TYPE->PAYLOAD, PAYLOAD->STOP after 8 bits, STOP->IDLE on stop=1, STOP->WAIT_IDLE on stop=0, WAIT_IDLE->IDLE when i_sin=1.
- REQ-013 Data payloads SHALL shift into a 64-bit register: packets 0..3 fill A MSB byte first, 4..7 fill B MSB byte first.
- REQ-014 Control payload SHALL be {1'b0, op[2:0], crc[3:0]}.
- REQ-015 CRC SHALL be the 4-bit remainder of {A, B, 1'b1, op} (68 bits, MSB first) times x^4 modulo x^4+x+1, serial LFSR init 4'b0000, updated one bit per payload-bit cycle.
- REQ-016 On control packet with exactly NDATA preceding data packets and matching CRC, o_a/o_b/o_op SHALL load and o_valid SHALL pulse with o_err=3'b000 in the cycle after the stop bit is sampled.
- REQ-017 Control packet with fewer than NDATA data packets, or a data packet beyond NDATA, SHALL set err_data.
- REQ-018 CRC mismatch with correct count SHALL set err_crc; err_data takes precedence (err_crc cleared when err_data set).
- REQ-019 Stop bit 0 SHALL set err_frame only, pulse o_valid, discard the frame, and enter WAIT_IDLE.
- REQ-020 On any error o_a/o_b/o_op SHALL hold previous values; data-packet counter and CRC SHALL clear so the next packet starts a new frame.
- REQ-021 Excess data packet error SHALL be reported at that packet's stop bit; following packets start a fresh frame.
- REQ-022 o_valid SHALL be high for exactly one cycle per reported frame, never two consecutive cycles.

Reset
- REQ-023 rst SHALL force IDLE, counters/CRC/shift register to 0, o_a=0, o_b=0, o_op=0, o_valid=0, o_err=0.
- REQ-024 rst asserted mid-packet SHALL abandon the frame without o_valid; next start bit after release begins a fresh frame.

Configuration
- REQ-025 Macro ALU_RX_CRC_EN defined: CRC computed and checked per REQ-015/018.
- REQ-026 Macro undefined: CRC logic not compiled, crc field ignored, err_crc always 0.

Structure
- REQ-027 Shared package alu_pkg SHALL hold the FSM state enum, packet type enum, CRC polynomial constant 4'b0011 (implicit x^4), packet length constant 11, and error-bit index constants.
- REQ-028 One sub-module alu_crc4_serial (clear, enable, bit in, 4-bit remainder out) SHALL implement the LFSR; present only under ALU_RX_CRC_EN.

Verification
- REQ-029 A=0, B=0, op=000, control payload 0x0B -> o_valid pulse, o_err=000, o_a=0, o_b=0, o_op=0.
- REQ-030 Same frame with control payload 0x0A -> o_err=010, outputs unchanged; without ALU_RX_CRC_EN -> o_err=000.
- REQ-031 7 data packets then control -> o_err=001; 9 data packets -> o_err=001 at 9th stop bit.
- REQ-032 Stop bit 0 on packet 3 -> o_err=100, no output until i_sin returns high; next correct frame accepted.
- REQ-033 A=0x01234567, B=0x89ABCDEF, op=101 with bench-model CRC -> o_a/o_b/o_op match, o_err=000, o_valid 1 cycle after stop bit.
- REQ-034 rst asserted during packet 5 -> no o_valid, all outputs 0; following full frame accepted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the serial ALU packet deserializer.
package alu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TYPE,
    ST_PAYLOAD,
    ST_STOP,
    ST_WAIT_IDLE
  } state_e;

  typedef enum logic {
    PKT_DATA = 1'b0,
    PKT_CTRL = 1'b1
  } pkt_type_e;

  // Low four coefficients of x^4+x+1; the x^4 term is implicit.
  localparam logic [3:0] CRC_POLY = 4'b0011;

  localparam int PKT_LEN  = 11;
  localparam int PAY_BITS = PKT_LEN - 3;

  localparam int ERR_DATA_BIT  = 0;
  localparam int ERR_CRC_BIT   = 1;
  localparam int ERR_FRAME_BIT = 2;

  function automatic logic [2:0] err_mask(input int idx);
    return 3'(1) << idx;
  endfunction

endpackage

// File: rtl/alu_crc4_serial.sv
// Serial CRC-4 LFSR (x^4+x+1), one message bit per enabled cycle; synchronous clear wins over enable.
// Only built when ALU_RX_CRC_EN is defined.
`ifdef ALU_RX_CRC_EN
module alu_crc4_serial
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [3:0] rem
);

  always_ff @(posedge clk) begin
    if (clr) begin
      rem <= 4'b0000;
    end else if (en) begin
      rem <= {rem[2:0], 1'b0} ^ ({4{rem[3] ^ bit_in}} & CRC_POLY);
    end
  end

endmodule
`endif

// File: rtl/alu_packet_deser.sv
// Deserializes NDATA data packets plus one control packet into ALU operands; o_valid pulses one
// cycle after the reporting stop bit, no backpressure. CRC checking is compiled in with ALU_RX_CRC_EN.
module alu_packet_deser
  import alu_pkg::*;
#(
  parameter int NDATA = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sin,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [2:0]  o_op,
  output logic        o_valid,
  output logic [2:0]  o_err
);

  localparam int SR_W  = NDATA * 8;
  localparam int CNT_W = $clog2(NDATA + 1);
  localparam logic [CNT_W-1:0] NDATA_CNT = CNT_W'(NDATA);

  state_e           state;
  pkt_type_e        pkt_type;
  logic [2:0]       bit_cnt;
  logic [7:0]       pay;
  logic [CNT_W-1:0] data_cnt;
  logic [SR_W-1:0]  sr;
  logic             crc_ok;

`ifdef ALU_RX_CRC_EN
  logic       crc_clr;
  logic       crc_en;
  logic       crc_bit;
  logic [3:0] crc_rem;

  // Control payload contributes {1'b1, op}: its leading 0 is replaced by the marker bit and the
  // trailing crc field is not fed into the remainder.
  always_comb begin
    crc_en  = (state == ST_PAYLOAD) && (pkt_type == PKT_DATA || bit_cnt < 3'd4);
    crc_bit = (pkt_type == PKT_CTRL && bit_cnt == 3'd0) ? 1'b1 : i_sin;
    crc_clr = rst || (state == ST_STOP &&
              (!i_sin || pkt_type == PKT_CTRL || data_cnt == NDATA_CNT));
  end

  alu_crc4_serial u_crc (
    .clk    (clk),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (crc_bit),
    .rem    (crc_rem)
  );

  assign crc_ok = (crc_rem == pay[3:0]);
`else
  assign crc_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pkt_type <= PKT_DATA;
      bit_cnt  <= '0;
      pay      <= '0;
      data_cnt <= '0;
      sr       <= '0;
      o_a      <= '0;
      o_b      <= '0;
      o_op     <= '0;
      o_valid  <= 1'b0;
      o_err    <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!i_sin) state <= ST_TYPE;
        end
        ST_TYPE: begin
          pkt_type <= pkt_type_e'(i_sin);
          bit_cnt  <= '0;
          state    <= ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          pay     <= {pay[6:0], i_sin};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'(PAY_BITS - 1)) state <= ST_STOP;
        end
        ST_STOP: begin
          if (!i_sin) begin
            // Framing error discards the frame and waits for the line to idle high.
            o_valid  <= 1'b1;
            o_err    <= err_mask(ERR_FRAME_BIT);
            data_cnt <= '0;
            sr       <= '0;
            state    <= ST_WAIT_IDLE;
          end else begin
            state <= ST_IDLE;
            if (pkt_type == PKT_DATA) begin
              if (data_cnt == NDATA_CNT) begin
                o_valid  <= 1'b1;
                o_err    <= err_mask(ERR_DATA_BIT);
                data_cnt <= '0;
                sr       <= '0;
              end else begin
                sr       <= {sr[SR_W-9:0], pay};
                data_cnt <= data_cnt + 1'b1;
              end
            end else begin
              o_valid  <= 1'b1;
              data_cnt <= '0;
              sr       <= '0;
              if (data_cnt != NDATA_CNT) begin
                o_err <= err_mask(ERR_DATA_BIT);
              end else if (!crc_ok) begin
                o_err <= err_mask(ERR_CRC_BIT);
              end else begin
                o_err <= '0;
                o_a   <= sr[SR_W-1 -: 32];
                o_b   <= sr[31:0];
                o_op  <= pay[6:4];
              end
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (i_sin) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_packet_deser.sv
// Randomized bench for alu_packet_deser against a frame-level reference model.
module tb_alu_packet_deser;

  localparam int NDATA = 8;
`ifdef ALU_RX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_sin;
  logic [31:0] o_a;
  logic [31:0] o_b;
  logic [2:0]  o_op;
  logic        o_valid;
  logic [2:0]  o_err;

  int checks = 0;
  int errors = 0;
  int exp_pulses = 0;
  int obs_pulses = 0;
  int dbl_pulses = 0;
  logic prev_vld = 1'b0;

  logic [7:0]  bytes_q[$];
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [2:0]  m_op = '0;

  alu_packet_deser #(.NDATA(NDATA)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_sin   (i_sin),
    .o_a     (o_a),
    .o_b     (o_b),
    .o_op    (o_op),
    .o_valid (o_valid),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      obs_pulses++;
      if (prev_vld === 1'b1) dbl_pulses++;
    end
    prev_vld = o_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Polynomial long division of {A, B, 1, op} * x^4 by x^4+x+1.
  function automatic logic [3:0] crc_ref(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    logic [71:0] m;
    m = {a, b, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  task automatic model_pkt(input bit typ, input logic [7:0] pay, input bit stop,
                           output bit vld, output logic [2:0] err);
    logic [31:0] a, b;
    vld = 1'b0;
    err = 3'b000;
    if (!stop) begin
      vld = 1'b1;
      err = 3'b100;
      bytes_q.delete();
    end else if (!typ) begin
      if (bytes_q.size() == NDATA) begin
        vld = 1'b1;
        err = 3'b001;
        bytes_q.delete();
      end else begin
        bytes_q.push_back(pay);
      end
    end else begin
      vld = 1'b1;
      if (bytes_q.size() != NDATA) begin
        err = 3'b001;
      end else begin
        a = {bytes_q[0], bytes_q[1], bytes_q[2], bytes_q[3]};
        b = {bytes_q[4], bytes_q[5], bytes_q[6], bytes_q[7]};
        if (CRC_ON && crc_ref(a, b, pay[6:4]) != pay[3:0]) begin
          err = 3'b010;
        end else begin
          m_a  = a;
          m_b  = b;
          m_op = pay[6:4];
        end
      end
      bytes_q.delete();
    end
    if (vld) exp_pulses++;
  endtask

  task automatic send_bit(input logic b);
    i_sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic pkt_and_check(input bit typ, input logic [7:0] pay, input bit stop,
                               input string tag);
    bit         vld;
    logic [2:0] err;
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(pay[i]);
    send_bit(stop);
    model_pkt(typ, pay, stop, vld, err);
    check({tag, "_vld"}, 64'(o_valid), 64'(vld));
    if (vld) check({tag, "_err"}, 64'(o_err), 64'(err));
    check({tag, "_a"}, 64'(o_a), 64'(m_a));
    check({tag, "_b"}, 64'(o_b), 64'(m_b));
    check({tag, "_op"}, 64'(o_op), 64'(m_op));
  endtask

  // ndata may differ from NDATA; above NDATA no control packet follows. bad_idx marks a data
  // packet sent with a 0 stop bit, after which the line is held low for a while.
  task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input int ndata, input logic [3:0] crc_flip, input int bad_idx,
                            input string tag);
    logic [63:0] ab;
    logic [7:0]  byt;
    logic [3:0]  crc;
    ab = {a, b};
    for (int i = 0; i < ndata; i++) begin
      byt = (i < NDATA) ? ab[63 - 8*i -: 8] : 8'($urandom);
      if (i == bad_idx) begin
        pkt_and_check(1'b0, byt, 1'b0, {tag, "_badstop"});
        repeat ($urandom_range(1, 4)) begin
          send_bit(1'b0);
          check({tag, "_waitlow"}, 64'(o_valid), 64'd0);
        end
        send_bit(1'b1);
        return;
      end
      pkt_and_check(1'b0, byt, 1'b1, {tag, "_data"});
      repeat ($urandom_range(0, 2)) send_bit(1'b1);
    end
    if (ndata <= NDATA) begin
      crc = crc_ref(a, b, op) ^ crc_flip;
      pkt_and_check(1'b1, {1'b0, op, crc}, 1'b1, {tag, "_ctrl"});
    end
    repeat ($urandom_range(0, 2)) send_bit(1'b1);
  endtask

  initial begin
    int sel, nd, bad;
    logic [3:0] flip;
    rst   = 1'b1;
    i_sin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a", 64'(o_a), 64'd0);
    check("rst_b", 64'(o_b), 64'd0);
    check("rst_op", 64'(o_op), 64'd0);
    check("rst_vld", 64'(o_valid), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    rst = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);

    send_frame(32'h0, 32'h0, 3'b000, NDATA, 4'h0, -1, "zero_good");
    send_frame(32'h0, 32'h0, 3'b000, NDATA, 4'h1, -1, "zero_badcrc");
    send_frame(32'h11112222, 32'h33334444, 3'b010, 7, 4'h0, -1, "short");
    send_frame(32'h55556666, 32'h77778888, 3'b011, 9, 4'h0, -1, "long");
    send_frame(32'hA5A5A5A5, 32'h5A5A5A5A, 3'b110, NDATA, 4'h0, 3, "framing");
    send_frame(32'hCAFEF00D, 32'hDEADBEEF, 3'b111, NDATA, 4'h0, -1, "after_frame");
    send_frame(32'h01234567, 32'h89ABCDEF, 3'b101, NDATA, 4'h0, -1, "known");

    // Reset in the middle of the sixth packet of a frame.
    for (int i = 0; i < 5; i++) pkt_and_check(1'b0, 8'($urandom), 1'b1, "pre_rst");
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst   = 1'b1;
    i_sin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bytes_q.delete();
    m_a  = '0;
    m_b  = '0;
    m_op = '0;
    check("midrst_a", 64'(o_a), 64'd0);
    check("midrst_b", 64'(o_b), 64'd0);
    check("midrst_op", 64'(o_op), 64'd0);
    check("midrst_vld", 64'(o_valid), 64'd0);
    check("midrst_err", 64'(o_err), 64'd0);
    send_bit(1'b1);
    send_frame(32'h0BADC0DE, 32'h600DF00D, 3'b001, NDATA, 4'h0, -1, "post_rst");

    for (int f = 0; f < 24; f++) begin
      sel  = $urandom_range(0, 9);
      nd   = (sel == 0) ? $urandom_range(0, 7) : (sel == 1) ? 9 : NDATA;
      flip = (sel == 2) ? 4'($urandom_range(1, 15)) : 4'h0;
      bad  = (sel == 3) ? $urandom_range(0, NDATA - 1) : -1;
      send_frame($urandom, $urandom, 3'($urandom_range(0, 7)), nd, flip, bad, "rand");
    end

    send_bit(1'b1);
    send_bit(1'b1);
    check("pulse_count", 64'(obs_pulses), 64'(exp_pulses));
    check("no_double", 64'(dbl_pulses), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
